// File: rtl/max_pool_fp_stream.sv
// Streaming max-pool over WINDOW IEEE-754 words with a valid/ready handshake on both sides.
// Optional macro MAXPOOL_NAN_CHECK_EN turns on sticky NaN detection with a canonical quiet-NaN result.
module max_pool_fp_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int WINDOW     = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_max,
  output logic [IDX_WIDTH-1:0]  o_index,
  output logic                  o_nan,
  output logic                  o_valid,
  input  logic                  i_ready
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  typedef enum logic {ACC, OUT} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] max_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic                  in_xfer, out_xfer, first, last;

  // Strict bit-pattern ordering: positive beats negative (+0 > -0); negatives order by smaller magnitude.
  function automatic logic greater(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) return !a[DATA_WIDTH-1];
    else if (!a[DATA_WIDTH-1])             return a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0];
    else                                   return a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0];
  endfunction

  assign o_valid  = (state_q == OUT);
  assign o_ready  = (state_q == ACC) || i_ready;
  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = o_valid && i_ready;
  assign first    = (count_q == '0);
  assign last     = (count_q == LAST);
  assign o_max    = max_q;
  assign o_index  = idx_q;

  always_comb begin
    // NOTE: next state defaults to the current state first so no path leaves it unassigned (no latch).
    state_d = state_q;
    if (in_xfer && last) state_d = OUT;
    else if (out_xfer)   state_d = ACC;
  end

  always_ff @(posedge clk) begin
    // NOTE: all clocked state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      state_q <= ACC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_xfer) count_q <= last ? '0 : count_q + 1'b1;
    end
  end

`ifdef MAXPOOL_NAN_CHECK_EN
  localparam int MANT_W = DATA_WIDTH - 9;
  localparam logic [DATA_WIDTH-1:0] QNAN = DATA_WIDTH'(10'h1FF) << (DATA_WIDTH - 10);

  logic nan_q, elem_nan;

  assign elem_nan = (&i_data[DATA_WIDTH-2:MANT_W]) && (|i_data[MANT_W-1:0]);
  assign o_nan    = nan_q;

  // Once a NaN has been seen the window result is frozen at the canonical NaN and its first position.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
      nan_q <= 1'b0;
    end else if (in_xfer) begin
      if (first) begin
        nan_q <= elem_nan;
        max_q <= elem_nan ? QNAN : i_data;
        idx_q <= '0;
      end else if (!nan_q) begin
        if (elem_nan) begin
          nan_q <= 1'b1;
          max_q <= QNAN;
          idx_q <= IDX_WIDTH'(count_q);
        end else if (greater(i_data, max_q)) begin
          max_q <= i_data;
          idx_q <= IDX_WIDTH'(count_q);
        end
      end
    end
  end
`else
  assign o_nan = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (in_xfer) begin
      if (first || greater(i_data, max_q)) begin
        max_q <= i_data;
        idx_q <= first ? '0 : IDX_WIDTH'(count_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_max_pool_fp_stream.sv
// Self-checking bench for max_pool_fp_stream: WINDOW=4 instance with a window-level model,
// plus a WINDOW=1 instance for full-rate pass-through.
module tb_max_pool_fp_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic        o_ready, o_nan, o_valid;
  logic [31:0] o_max;
  logic [1:0]  o_index;

  logic [31:0] d1_data = '0;
  logic        d1_valid = 1'b0;
  logic        d1_iready = 1'b1;
  logic        d1_oready, d1_nan, d1_ovalid;
  logic [31:0] d1_max;
  logic [0:0]  d1_index;

  always #5 clk = ~clk;

  max_pool_fp_stream #(.DATA_WIDTH(32), .WINDOW(4), .IDX_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_max(o_max), .o_index(o_index), .o_nan(o_nan), .o_valid(o_valid), .i_ready(i_ready));

  max_pool_fp_stream #(.DATA_WIDTH(32), .WINDOW(1), .IDX_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .i_data(d1_data), .i_valid(d1_valid), .o_ready(d1_oready),
    .o_max(d1_max), .o_index(d1_index), .o_nan(d1_nan), .o_valid(d1_ovalid), .i_ready(d1_iready));

  typedef struct {
    logic [31:0] mx;
    logic [1:0]  idx;
    logic        nan;
  } res_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] win_q[$];
  res_t        exp_q[$];
  logic        exp_valid = 1'b0;
  logic        rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Map a bit pattern onto an unsigned key whose natural order is the required float order.
  function automatic logic [31:0] okey(input logic [31:0] b);
    return b[31] ? ~b : (b | 32'h8000_0000);
  endfunction

  function automatic logic is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  function automatic res_t pool(input logic [31:0] w[$]);
    res_t r;
    r.mx  = w[0];
    r.idx = 2'd0;
    r.nan = 1'b0;
    for (int i = 1; i < 4; i++)
      if (okey(w[i]) > okey(r.mx)) begin
        r.mx  = w[i];
        r.idx = 2'(i);
      end
`ifdef MAXPOOL_NAN_CHECK_EN
    for (int i = 3; i >= 0; i--)
      if (is_nan(w[i])) begin
        r.mx  = 32'h7FC0_0000;
        r.idx = 2'(i);
        r.nan = 1'b1;
      end
`endif
    return r;
  endfunction

  // Compare process: looks at the outputs mid-cycle and predicts what the coming edge transfers.
  initial begin
    logic        hold, out_x, in_x;
    logic [31:0] h_max;
    logic [1:0]  h_idx;
    logic        h_nan;
    res_t        r;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        win_q.delete();
        exp_q.delete();
        exp_valid = 1'b0;
        hold = 1'b0;
      end else begin
        check("o_valid", 32'(o_valid), 32'(exp_valid));
        check("o_ready", 32'(o_ready), exp_valid ? 32'(i_ready) : 32'd1);
        if (hold) begin
          check("hold_max", o_max, h_max);
          check("hold_index", 32'(o_index), 32'(h_idx));
          check("hold_nan", 32'(o_nan), 32'(h_nan));
        end
        out_x = o_valid && i_ready;
        in_x  = i_valid && o_ready;
        hold  = o_valid && !i_ready;
        h_max = o_max;
        h_idx = o_index;
        h_nan = o_nan;
        if (out_x) begin
          if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
          else begin
            r = exp_q.pop_front();
            check("res_max", o_max, r.mx);
            check("res_index", 32'(o_index), 32'(r.idx));
            check("res_nan", 32'(o_nan), 32'(r.nan));
          end
          exp_valid = 1'b0;
        end
        if (in_x) begin
          win_q.push_back(i_data);
          if (win_q.size() == 4) begin
            exp_q.push_back(pool(win_q));
            win_q.delete();
            exp_valid = 1'b1;
          end
        end
      end
    end
  end

  // Present one element and hold it until the DUT accepts it; leaves i_valid high.
  task automatic send(input logic [31:0] d);
    logic acc;
    i_data  = d;
    i_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (rand_rdy) i_ready = 1'($urandom_range(0, 1));
      if (acc) return;
    end
    check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic send_win(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
    i_valid = 1'b0;
  endtask

  task automatic check_res(input string name, input logic [31:0] mx, input logic [1:0] idx,
                           input logic nan);
    check({name, "_valid"}, 32'(o_valid), 32'd1);
    check({name, "_max"}, o_max, mx);
    check({name, "_index"}, 32'(o_index), 32'(idx));
    check({name, "_nan"}, 32'(o_nan), 32'(nan));
  endtask

  logic [31:0] vals[8] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h8000_0000,
                           32'h7F80_0000, 32'h4049_0FDB, 32'hC120_0000, 32'h0000_0001};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_max", o_max, 32'd0);
    check("rst_index", 32'(o_index), 32'd0);
    check("rst_nan", 32'(o_nan), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", 32'(o_ready), 32'd1);

    // Mixed signs; then all-negative with a tie; then signed zeros.
    send_win(32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 32'h3F00_0000);
    check_res("win_basic", 32'h4000_0000, 2'd1, 1'b0);
    send_win(32'hC000_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hC040_0000);
    check_res("win_neg_tie", 32'hBF80_0000, 2'd1, 1'b0);
    send_win(32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
    check_res("win_zero", 32'h0000_0000, 2'd1, 1'b0);

    // Backpressure with a pending input that must be ignored while stalled.
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    send_win(32'h3F80_0000, 32'h4080_0000, 32'h4080_0000, 32'h3F80_0000);
    i_valid = 1'b1;
    i_data  = 32'h7F00_0000;
    for (int n = 0; n < 5; n++) begin
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_ready", 32'(o_ready), 32'd0);
      check("bp_max", o_max, 32'h4080_0000);
      @(posedge clk);
      #1;
    end
    i_ready = 1'b1;
    send(32'h4100_0000);
    check("overlap_valid", 32'(o_valid), 32'd0);
    send(32'h3F80_0000);
    send(32'h4110_0000);
    send(32'h0000_0000);
    i_valid = 1'b0;
    check_res("win_overlap", 32'h4110_0000, 2'd2, 1'b0);

    // Reset after two elements discards them.
    @(posedge clk);
    #1;
    send(32'h4F00_0000);
    send(32'h4F00_0000);
    i_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_max", o_max, 32'd0);
    rst = 1'b0;
    send_win(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F00_0000);
    check_res("win_after_rst", 32'h4040_0000, 2'd2, 1'b0);

    send_win(32'h3F80_0000, 32'h7FC0_0001, 32'h4000_0000, 32'h7F80_0000);
`ifdef MAXPOOL_NAN_CHECK_EN
    check_res("win_nan", 32'h7FC0_0000, 2'd1, 1'b1);
`else
    check_res("win_nan", 32'h7FC0_0001, 2'd1, 1'b0);
`endif

    // Pseudo-random data and sink stalls, checked by the model only.
    rand_rdy = 1'b1;
    for (int w = 0; w < 6; w++) begin
      for (int e = 0; e < 4; e++) begin
        send($urandom);
        if ($urandom_range(0, 3) == 0) begin
          i_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      i_valid = 1'b0;
    end
    rand_rdy = 1'b0;
    i_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("drained_results", 32'(exp_q.size()), 32'd0);
    check("drained_partial", 32'(win_q.size()), 32'd0);

    // WINDOW=1: every accepted word comes straight back one cycle later at full rate.
    d1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d1_data = vals[i];
      @(posedge clk);
      #1;
      check("w1_valid", 32'(d1_ovalid), 32'd1);
      check("w1_ready", 32'(d1_oready), 32'd1);
      check("w1_max", d1_max, vals[i]);
      check("w1_index", 32'(d1_index), 32'd0);
    end
    d1_valid = 1'b0;
    @(posedge clk);
    #1;
    check("w1_idle_valid", 32'(d1_ovalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
